bcd_scan_counter: RTL and testbench
===================================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, giving clock cycles per displayed digit (legal range 1..65535).
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port en  input  1  count-increment request, sampled each rising edge.
REQ-005 Port clr  input  1  synchronous clear of the count value.
REQ-006 Port load  input  1  synchronous load of load_val into the count value.
REQ-007 Port load_val  input  16  four BCD digits, [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-008 Port count  output  16  current 4-digit BCD count, same nibble order as load_val.
REQ-009 Port carry_out  output  1  one-cycle pulse on 9999->0000 rollover.
REQ-010 Port bcd_out  output  4  BCD nibble of the digit currently selected for display, feeding the 7-segment decoder input.
REQ-011 Port digit_sel  output  4  one-hot active-high digit enable, bit 0 = units, bit 3 = thousands.

Function
REQ-012 Control priority SHALL be rst > clr > load > en; lower-priority inputs are ignored in a cycle where a higher one is asserted.
REQ-013 clr SHALL set count to 16'h0000 on the next edge.
REQ-014 load SHALL set count to load_val on the next edge, except that any nibble greater than 9 SHALL be stored as 0.
REQ-015 en SHALL increment count by one in decimal on the next edge: units 9->0 carries into tens, and so on up to thousands.
REQ-016 Count 9999 with en SHALL wrap to 0000, with carry_out high for exactly the following cycle.
REQ-017 carry_out SHALL be registered and SHALL be low in every other cycle, including after clr or load.
REQ-018 Holding en high SHALL increment once per cycle, with no gaps.
REQ-019 The scan prescaler SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-020 On the prescaler wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-021 With SCAN_DIV=1 the digit index SHALL advance every cycle.
REQ-022 The scan (prescaler and index) SHALL be affected only by rst, never by en, clr or load.
REQ-023 digit_sel SHALL be a registered one-hot decode of the digit index, and SHALL never be zero or multi-hot after reset.
REQ-024 bcd_out SHALL be combinational: count nibble[index], consistent with digit_sel in the same cycle.
REQ-025 bcd_out SHALL be at most 9 at all times.
REQ-026 A count change while a digit is displayed SHALL appear on bcd_out in the cycle after the updating edge.

Reset
REQ-027 When rst is high at an edge, the following SHALL take effect on the next cycle:
- count = 16'h0000
- carry_out = 0
- prescaler = 0
- digit index = 0
- digit_sel = 4'b0001
- bcd_out = 4'h0
REQ-028 rst asserted mid-count or mid-scan SHALL abort immediately with no carry_out pulse, regardless of en, clr and load.
REQ-029 After rst deasserts, the first increment SHALL occur on the first edge with en=1.

Verification
REQ-030 Reset, then en=1 for 12 cycles -> count = 16'h0012, carry_out never asserted.
REQ-031 load with load_val=16'h9998, then en for 2 cycles -> count 9999 then 0000; carry_out high for exactly the one cycle after the 0000 edge.
REQ-032 load with load_val=16'h3A7F -> count = 16'h3070.
REQ-033 clr, load and en all high with count=16'h0042 -> count = 16'h0000; then load and en high with load_val=16'h0100 -> count = 16'h0100, not 0101.
REQ-034 SCAN_DIV=4, count=16'h1234, run 16 cycles after reset:
- digit_sel steps 0001,0010,0100,1000, four cycles each
- bcd_out steps 4,3,2,1 in lockstep
REQ-035 rst asserted during the 9999->0000 edge with en=1 -> count=0000, carry_out stays 0, digit_sel=0001 on the next cycle.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD counter with clear/load/increment and a multiplexed-display digit scanner.
// Latency: count, carry_out and digit_sel update one edge after their cause; bcd_out is combinational from count/index.
// No backpressure: en is an unconditional increment request; the scan runs freely and only rst touches it.
//
// Ports: clk, rst (sync, active-high); en/clr/load with priority rst > clr > load > en;
//        load_val/count are 4 BCD nibbles ([3:0] units .. [15:12] thousands);
//        carry_out pulses one cycle after a 9999->0000 increment;
//        digit_sel is the one-hot digit enable (bit 0 = units), bcd_out the selected digit's nibble.
module bcd_scan_counter #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        carry_out,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_sel
);

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] count_q, count_d;
    logic        carry_q, carry_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  digit_sel_q, digit_sel_d;

    logic [15:0] inc_val;
    logic [15:0] load_clean;
    logic [4:0]  dig_carry;

    // Decimal increment as a ripple of per-digit carries; dig_carry[4] set means the
    // value was 9999 and the increment wraps to 0000.
    always_comb begin
        inc_val      = count_q;
        dig_carry    = 5'b00000;
        dig_carry[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dig_carry[i]) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                    dig_carry[i+1]    = 1'b1;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    // Non-decimal nibbles are stored as zero so count never holds an illegal digit.
    always_comb begin
        load_clean = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (clr) begin
            count_d = 16'h0000;
        end else if (load) begin
            count_d = load_clean;
        end else if (en) begin
            count_d = inc_val;
            carry_d = dig_carry[4];
        end
    end

    // Scan: prescaler wraps at SCAN_DIV-1 and advances the digit index. digit_sel is
    // decoded from the next index so the registered one-hot always matches idx_q.
    always_comb begin
        presc_d = presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q >= PRESC_MAX) begin
            presc_d = 16'd0;
            idx_d   = idx_q + 2'd1;
        end
        digit_sel_d = 4'b0001 << idx_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 16'h0000;
            carry_q     <= 1'b0;
            presc_q     <= 16'd0;
            idx_q       <= 2'd0;
            digit_sel_q <= 4'b0001;
        end else begin
            count_q     <= count_d;
            carry_q     <= carry_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    always_comb begin
        bcd_out = count_q[3:0];
        case (idx_q)
            2'd0: bcd_out = count_q[3:0];
            2'd1: bcd_out = count_q[7:4];
            2'd2: bcd_out = count_q[11:8];
            2'd3: bcd_out = count_q[15:12];
            default: bcd_out = count_q[3:0];
        endcase
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

    localparam int unsigned DIV_A = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic        load;
    logic [15:0] load_val;

    logic [15:0] count_a, count_b;
    logic        carry_a, carry_b;
    logic [3:0]  bcd_a, bcd_b;
    logic [3:0]  dsel_a, dsel_b;

    int errors;
    int checks;
    int scan_cnt;

    bcd_scan_counter #(.SCAN_DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(count_a), .carry_out(carry_a), .bcd_out(bcd_a), .digit_sel(dsel_a)
    );

    bcd_scan_counter #(.SCAN_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(count_b), .carry_out(carry_b), .bcd_out(bcd_b), .digit_sel(dsel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; scan_cnt tracks edges since the last reset edge.
    task automatic tick;
        @(posedge clk);
        if (rst) scan_cnt = 0;
        else     scan_cnt = scan_cnt + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int idx);
        logic [15:0] s;
        s = v >> (4 * idx);
        nib = s[3:0];
    endfunction

    task automatic check_all(input string tag, input logic [15:0] ec, input logic ecar);
        int ia;
        int ib;
        logic [3:0] sa;
        logic [3:0] sb;
        ia = (scan_cnt / DIV_A) % 4;
        ib = scan_cnt % 4;
        sa = 4'b0001 << ia;
        sb = 4'b0001 << ib;
        chk({tag, ".count"},  {16'd0, count_a}, {16'd0, ec});
        chk({tag, ".carry"},  {31'd0, carry_a}, {31'd0, ecar});
        chk({tag, ".dsel"},   {28'd0, dsel_a},  {28'd0, sa});
        chk({tag, ".bcd"},    {28'd0, bcd_a},   {28'd0, nib(ec, ia)});
        chk({tag, ".count1"}, {16'd0, count_b}, {16'd0, ec});
        chk({tag, ".carry1"}, {31'd0, carry_b}, {31'd0, ecar});
        chk({tag, ".dsel1"},  {28'd0, dsel_b},  {28'd0, sb});
        chk({tag, ".bcd1"},   {28'd0, bcd_b},   {28'd0, nib(ec, ib)});
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        scan_cnt = 0;
        rst      = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;

        // Reset state
        tick;
        rst = 1'b0;
        check_all("reset", 16'h0000, 1'b0);

        // Scan walk with count 1234: units first, four cycles per digit
        load = 1'b1; load_val = 16'h1234;
        tick;
        load = 1'b0;
        check_all("scan_k1", 16'h1234, 1'b0);
        chk("scan_k1_bcd", {28'd0, bcd_a}, 32'h4);
        for (int k = 2; k < 16; k++) begin
            tick;
            check_all("scan", 16'h1234, 1'b0);
        end
        chk("scan_end_dsel", {28'd0, dsel_a}, 32'h8);
        chk("scan_end_bcd",  {28'd0, bcd_a},  32'h1);
        tick;
        chk("scan_wrap_dsel", {28'd0, dsel_a}, 32'h1);

        // Reset then 12 increments, no carry
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_all("reset2", 16'h0000, 1'b0);
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            check_all("inc", to_bcd(i), 1'b0);
        end
        en = 1'b0;
        tick;
        check_all("hold", 16'h0012, 1'b0);

        // Load sanitises non-decimal nibbles
        load = 1'b1; load_val = 16'h3A7F;
        tick;
        load = 1'b0;
        check_all("load_3A7F", 16'h3070, 1'b0);

        // 9998 -> 9999 -> 0000 with one-cycle carry
        load = 1'b1; load_val = 16'h9998;
        tick;
        load = 1'b0;
        check_all("load_9998", 16'h9998, 1'b0);
        en = 1'b1;
        tick;
        check_all("to_9999", 16'h9999, 1'b0);
        tick;
        en = 1'b0;
        check_all("wrap", 16'h0000, 1'b1);
        tick;
        check_all("after_wrap", 16'h0000, 1'b0);

        // en held across the wrap: carry only on the wrap cycle
        load = 1'b1; load_val = 16'h9999;
        tick;
        load = 1'b0; en = 1'b1;
        tick;
        check_all("wrap_held", 16'h0000, 1'b1);
        tick;
        en = 1'b0;
        check_all("post_wrap_held", 16'h0001, 1'b0);

        // Priority: clr over load and en; load over en
        load = 1'b1; load_val = 16'h0042;
        tick;
        load = 1'b0;
        check_all("load_0042", 16'h0042, 1'b0);
        clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 16'h0777;
        tick;
        clr = 1'b0;
        check_all("clr_prio", 16'h0000, 1'b0);
        load_val = 16'h0100;
        tick;
        load = 1'b0;
        check_all("load_prio", 16'h0100, 1'b0);
        tick;
        en = 1'b0;
        check_all("inc_after_load", 16'h0101, 1'b0);

        // clr or load at 9999 with en gives no carry
        load = 1'b1; load_val = 16'h9999;
        tick;
        load = 1'b0; clr = 1'b1; en = 1'b1;
        tick;
        clr = 1'b0; en = 1'b0;
        check_all("clr_at_9999", 16'h0000, 1'b0);
        load = 1'b1; load_val = 16'h9999;
        tick;
        en = 1'b1;
        tick;
        load = 1'b0; en = 1'b0;
        check_all("load_at_9999", 16'h9999, 1'b0);

        // Reset on the 9999 -> 0000 edge aborts the carry and restarts the scan
        rst = 1'b1; en = 1'b1; clr = 1'b1; load = 1'b1; load_val = 16'h0555;
        tick;
        rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        check_all("rst_on_wrap", 16'h0000, 1'b0);
        chk("rst_on_wrap_dsel", {28'd0, dsel_a}, 32'h1);
        tick;
        check_all("rst_on_wrap_next", 16'h0000, 1'b0);
        en = 1'b1;
        tick;
        en = 1'b0;
        check_all("first_inc_after_rst", 16'h0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
